// File: rtl/alu_datapath.sv
// Accumulator/carry datapath around a combinational 8-function ALU.
// A and CY feed the ALU and capture its result on enabled rising edges.
module alu_datapath #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             A_CE,
  input  logic             CY_CE,
  input  logic [2:0]       ALUCode,
  input  logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] A,
  output logic             CY,
  output logic [WIDTH-1:0] out,
  output logic             Co
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_LDR = 3'b110,
    OP_NOP = 3'b111
  } alu_op_e;

  alu_op_e          op;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;

  assign op = alu_op_e'(ALUCode);

  // One extra bit: carry out of the add, and borrow (sign) of the subtract.
  assign sum  = {1'b0, A} + {1'b0, R} + {{WIDTH{1'b0}}, CY};
  assign diff = {1'b0, A} - {1'b0, R} - {{WIDTH{1'b0}}, CY};

  always_comb begin
    out = A;
    Co  = 1'b0;
    case (op)
      OP_ADD: begin
        out = sum[WIDTH-1:0];
        Co  = sum[WIDTH];
      end
      OP_SUB: begin
        out = diff[WIDTH-1:0];
        Co  = diff[WIDTH];
      end
      OP_AND: out = A & R;
      OP_OR:  out = A | R;
      OP_XOR: out = A ^ R;
      OP_NOT: out = ~A;
      OP_LDR: out = R;
      OP_NOP: begin
        out = A;
        Co  = CY;
      end
      default: begin
        out = A;
        Co  = CY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      A  <= '0;
      CY <= 1'b0;
    end else begin
      if (A_CE)
        A <= out;
      if (CY_CE)
        CY <= Co;
    end
  end

endmodule

// File: tb/tb_alu_datapath.sv
// Directed self-checking bench for alu_datapath: one task per scenario,
// expected values hand-computed for WIDTH=8.
module tb_alu_datapath;

  localparam int unsigned WIDTH = 8;

  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;
  localparam logic [2:0] AND = 3'b010;
  localparam logic [2:0] OR_ = 3'b011;
  localparam logic [2:0] XOR = 3'b100;
  localparam logic [2:0] NOT = 3'b101;
  localparam logic [2:0] LDR = 3'b110;
  localparam logic [2:0] NOP = 3'b111;

  logic             clk;
  logic             nReset;
  logic             A_CE;
  logic             CY_CE;
  logic [2:0]       ALUCode;
  logic [WIDTH-1:0] R;
  logic [WIDTH-1:0] A;
  logic             CY;
  logic [WIDTH-1:0] out;
  logic             Co;

  int errors = 0;
  int checks = 0;

  alu_datapath #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .nReset  (nReset),
    .A_CE    (A_CE),
    .CY_CE   (CY_CE),
    .ALUCode (ALUCode),
    .R       (R),
    .A       (A),
    .CY      (CY),
    .out     (out),
    .Co      (Co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs are changed and outputs read here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] code, input logic [7:0] r,
                       input logic ace, input logic cce);
    ALUCode = code;
    R       = r;
    A_CE    = ace;
    CY_CE   = cce;
    #1;
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    drive(ADD, 8'd4, 1'b1, 1'b1);
    tick();
    tick();
    checks++;
    if (A !== 8'd0 || CY !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: A=%0d CY=%0b required A=0 CY=0", A, CY);
    end
    #1;
    checks++;
    if (out !== 8'd4 || Co !== 1'b0) begin
      errors++;
      $display("FAIL reset_comb: out=%0d Co=%0b required out=4 Co=0", out, Co);
    end
  endtask

  task automatic test_add_seq();
    logic [7:0] exp_a [3];
    exp_a[0] = 8'd4; exp_a[1] = 8'd8; exp_a[2] = 8'd12;
    nReset = 1'b1;
    drive(ADD, 8'd4, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (A !== exp_a[i] || CY !== 1'b0) begin
        errors++;
        $display("FAIL add_seq[%0d]: A=%0d CY=%0b required A=%0d CY=0", i, A, CY, exp_a[i]);
      end
    end
  endtask

  task automatic test_ldr_not_add();
    drive(LDR, 8'd4, 1'b1, 1'b1);
    tick();
    checks++;
    if (A !== 8'd4 || CY !== 1'b0) begin
      errors++;
      $display("FAIL ldr: A=%0d CY=%0b required A=4 CY=0", A, CY);
    end
    drive(NOT, 8'd10, 1'b1, 1'b1);
    tick();
    checks++;
    if (A !== 8'd251 || CY !== 1'b0) begin
      errors++;
      $display("FAIL not: A=%0d CY=%0b required A=251 CY=0", A, CY);
    end
    drive(ADD, 8'd10, 1'b1, 1'b1);
    tick();
    checks++;
    if (A !== 8'd5 || CY !== 1'b1) begin
      errors++;
      $display("FAIL add_carry_out: A=%0d CY=%0b required A=5 CY=1", A, CY);
    end
    tick();
    checks++;
    if (A !== 8'd16 || CY !== 1'b0) begin
      errors++;
      $display("FAIL add_carry_in: A=%0d CY=%0b required A=16 CY=0", A, CY);
    end
  endtask

  task automatic test_sub();
    logic [7:0] exp_a [3];
    logic       exp_c [3];
    exp_a[0] = 8'd6;   exp_c[0] = 1'b0;
    exp_a[1] = 8'd252; exp_c[1] = 1'b1;
    exp_a[2] = 8'd241; exp_c[2] = 1'b0;
    drive(SUB, 8'd10, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (A !== exp_a[i] || CY !== exp_c[i]) begin
        errors++;
        $display("FAIL sub[%0d]: A=%0d CY=%0b required A=%0d CY=%0b", i, A, CY, exp_a[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_bitwise();
    logic [2:0] ops   [3];
    logic [7:0] exp_a [3];
    ops[0] = AND; exp_a[0] = 8'h08;
    ops[1] = OR_; exp_a[1] = 8'h0E;
    ops[2] = XOR; exp_a[2] = 8'h06;
    for (int i = 0; i < 3; i++) begin
      drive(LDR, 8'h0C, 1'b1, 1'b1);
      tick();
      drive(ops[i], 8'h0A, 1'b1, 1'b1);
      tick();
      checks++;
      if (A !== exp_a[i] || CY !== 1'b0) begin
        errors++;
        $display("FAIL bitwise[%0d]: A=%h CY=%0b required A=%h CY=0", i, A, CY, exp_a[i]);
      end
    end
  endtask

  task automatic test_hold();
    drive(LDR, 8'hF0, 1'b1, 1'b1);
    tick();
    // Carry-only update: A keeps 0xF0 while CY picks up the add carry.
    drive(ADD, 8'h20, 1'b0, 1'b1);
    tick();
    checks++;
    if (A !== 8'hF0 || CY !== 1'b1) begin
      errors++;
      $display("FAIL cy_only: A=%h CY=%0b required A=f0 CY=1", A, CY);
    end
    drive(ADD, 8'h20, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (A !== 8'hF0 || CY !== 1'b1 || out !== 8'h11 || Co !== 1'b1) begin
        errors++;
        $display("FAIL hold[%0d]: A=%h CY=%0b out=%h Co=%0b required A=f0 CY=1 out=11 Co=1",
                 i, A, CY, out, Co);
      end
    end
  endtask

  task automatic test_a_only();
    drive(LDR, 8'h11, 1'b1, 1'b0);
    tick();
    drive(ADD, 8'h01, 1'b1, 1'b0);
    checks++;
    if (out !== 8'h13 || Co !== 1'b0) begin
      errors++;
      $display("FAIL a_only_comb: out=%h Co=%0b required out=13 Co=0", out, Co);
    end
    tick();
    checks++;
    if (A !== 8'h13 || CY !== 1'b1) begin
      errors++;
      $display("FAIL a_only: A=%h CY=%0b required A=13 CY=1", A, CY);
    end
  endtask

  task automatic test_nop();
    drive(NOP, 8'hAA, 1'b1, 1'b1);
    checks++;
    if (out !== 8'h13 || Co !== 1'b1) begin
      errors++;
      $display("FAIL nop_comb: out=%h Co=%0b required out=13 Co=1", out, Co);
    end
    tick();
    tick();
    checks++;
    if (A !== 8'h13 || CY !== 1'b1) begin
      errors++;
      $display("FAIL nop_state: A=%h CY=%0b required A=13 CY=1", A, CY);
    end
  endtask

  task automatic test_boundaries();
    drive(LDR, 8'hFF, 1'b1, 1'b0);
    tick();
    drive(ADD, 8'hFF, 1'b0, 1'b0);
    checks++;
    if (out !== 8'hFF || Co !== 1'b1) begin
      errors++;
      $display("FAIL add_max: out=%h Co=%0b required out=ff Co=1", out, Co);
    end
    drive(LDR, 8'h00, 1'b1, 1'b0);
    tick();
    drive(SUB, 8'hFF, 1'b0, 1'b0);
    checks++;
    if (out !== 8'h00 || Co !== 1'b1) begin
      errors++;
      $display("FAIL sub_min: out=%h Co=%0b required out=00 Co=1", out, Co);
    end
    drive(SUB, 8'h00, 1'b0, 1'b0);
    checks++;
    if (out !== 8'hFF || Co !== 1'b1) begin
      errors++;
      $display("FAIL sub_cy_only: out=%h Co=%0b required out=ff Co=1", out, Co);
    end
  endtask

  task automatic test_glitch_reset();
    drive(LDR, 8'd241, 1'b1, 1'b0);
    tick();
    drive(NOP, 8'd0, 1'b0, 1'b0);
    #1 nReset = 1'b0;
    #2 nReset = 1'b1;
    tick();
    checks++;
    if (A !== 8'd241 || CY !== 1'b1) begin
      errors++;
      $display("FAIL glitch_reset: A=%0d CY=%0b required A=241 CY=1", A, CY);
    end
  endtask

  task automatic test_reset_mid();
    nReset = 1'b0;
    drive(ADD, 8'd4, 1'b1, 1'b1);
    tick();
    checks++;
    if (A !== 8'd0 || CY !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: A=%0d CY=%0b required A=0 CY=0", A, CY);
    end
    nReset = 1'b1;
    tick();
    checks++;
    if (A !== 8'd4 || CY !== 1'b0) begin
      errors++;
      $display("FAIL resume: A=%0d CY=%0b required A=4 CY=0", A, CY);
    end
  endtask

  initial begin
    nReset  = 1'b0;
    A_CE    = 1'b0;
    CY_CE   = 1'b0;
    ALUCode = NOP;
    R       = '0;
    test_reset();
    test_add_seq();
    test_ldr_not_add();
    test_sub();
    test_bitwise();
    test_hold();
    test_a_only();
    test_nop();
    test_boundaries();
    test_glitch_reset();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
